branch_resolution_unit: RTL and testbench
=========================================

Name: branch_resolution_unit

Overview:
- Memory-stage counterpart of the two-wide branch predictor; the predictor's update port is this block's output.
- Takes up to two resolved branches per cycle from EX, each with the prediction made at fetch.
- Detects mispredicts, drives the predictor's BHT/BTB update strobes and the fetch redirect, and runs a flush window that squashes wrong-path resolves.
- Keeps saturating branch and mispredict statistics.

Parameters:
- PC_W, 11, PC/target width; matches the instruction-memory address width.
- FLUSH_CYCLES, 2, cycles flush stays high after a mispredict (legal range 1..15).
- CNT_W, 16, width of the statistics counters.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-low; sampled on the rising edge of clk.
- stall  in  1  pipeline stall; freezes the block.
- valid1, valid2  in  1  EX slot holds a resolved branch; slot 1 is older.
- pcE1, pcE2  in  PC_W  branch PC per slot.
- actualTaken1, actualTaken2  in  1  resolved direction.
- actualTarget1, actualTarget2  in  PC_W  resolved taken-target.
- predTaken1, predTaken2  in  1  direction predicted at fetch.
- predTarget1, predTarget2  in  PC_W  target predicted at fetch.
- branch1, branch2  out  1  predictor update strobe (registered).
- branch_taken1, branch_taken2  out  1  outcome for the update.
- pcM1, pcM2  out  PC_W  PC of the updated branch.
- targetM1, targetM2  out  PC_W  actual target for the BTB write.
- redirect  out  1  one-cycle fetch redirect pulse.
- redirectPC  out  PC_W  correct next PC.
- flush  out  1  squash younger pipeline stages.
- branchCount, mispredCount  out  CNT_W  saturating statistics.

Behaviour:
- Reset (reset==0 at a clk edge): all outputs 0, state=RUN, flush counter 0. Reset has priority over stall and over an active flush window.
- Mispredict for slot k: valid_k && (predTaken_k != actualTaken_k || (actualTaken_k && predTarget_k != actualTarget_k)).
- Correct PC for slot k: actualTaken_k ? actualTarget_k : pcE_k + 1, computed mod 2^PC_W (2047+1 wraps to 0).
- Accept condition: stall==0 && state==RUN.
- Accepted slot 1 always updates. Slot 2 updates only if slot 1 did not mispredict; otherwise slot 2 is wrong-path and is dropped.
- Latency: inputs accepted at edge N appear on branchK/branch_takenK/pcMK/targetMK at N+1. Update strobes are single-cycle; they are 0 in any cycle without an accepted update.
- targetMK = actualTargetK. pcMK = pcEK.
- Redirect: if any accepted slot mispredicts, redirect=1 for exactly one cycle (N+1).
  - redirectPC = correct PC of the oldest mispredicting slot.
  - When both slots mispredict, slot 1 wins.
  - redirectPC holds its last value when redirect=0.
- State machine:
  - RUN: on mispredict go to FLUSH; flush=1 from N+1; counter loads FLUSH_CYCLES-1.
  - FLUSH: all inputs ignored (no updates, no redirect, no stats).
    - Each non-stalled cycle: if counter==0, go to RUN and drop flush; else decrement.
    - flush is therefore high for exactly FLUSH_CYCLES non-stalled cycles.
  - Stall in either state: state, counter and statistics hold; update strobes and redirect are 0; flush holds its value.
- Statistics, per accepted cycle:
  - branchCount += number of updating slots (0..2).
  - mispredCount += 1 when a mispredict occurs.
  - Both counters saturate at 2^CNT_W-1, including when an add of 2 would cross the maximum.
- Simultaneous events: a mispredict is never accepted while in FLUSH. valid inputs arriving with stall=1 are not consumed; EX re-presents them.

Decomposition:
- Package branch_pkg holds:
  - PC_W;
  - state encoding RUN=1'b0, FLUSH=1'b1;
  - function is_mispredict(predTaken, predTarget, actualTaken, actualTarget);
  - function correct_pc(pc, actualTaken, actualTarget).
- One combinational sub-module, branch_compare, instantiated per slot. It produces mispredict and correctPC.
- The top level owns the FSM, output registers and counters.

Test Plan:
- Reset: drive reset=0 mid-FLUSH → next edge all outputs 0, state RUN; valid1 on the following cycle is accepted.
- Correct prediction: slot1 pc=0x010, predTaken=1, predTarget=0x040, actual taken to 0x040 → N+1: branch1=1, branch_taken1=1, pcM1=0x010, targetM1=0x040, redirect=0, branchCount=1.
- Direction mispredict: slot1 pc=0x7FF, predTaken=1, actual not-taken → redirect=1 with redirectPC=0x000 (wrap); flush high 2 cycles; valid inputs during those cycles produce no strobes.
- Dual slots, slot 1 mispredicts: slot1 target mismatch (pred 0x020, actual 0x030), slot2 valid → branch1=1, branch2=0, redirectPC=0x030, branchCount+1, mispredCount+1.
- Slot 2 only mispredicts: slot1 correct, slot2 pred not-taken, actual taken to 0x100 → branch1=branch2=1, redirectPC=0x100, branchCount+2.
- Stall and saturation: stall=1 with valid1 → no strobes, counters hold. Preload branchCount=0xFFFE, accept a dual correct pair → branchCount=0xFFFF.

Source files
------------

// File: rtl/branch_pkg.sv
// Shared types and pure helpers for the branch resolution unit.
// PC_W here is the width the compare helpers operate on; the top's PC_W must match it.
package branch_pkg;

    localparam int PC_W = 11;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } bru_state_e;

    function automatic logic is_mispredict(
        input logic            pred_taken,
        input logic [PC_W-1:0] pred_target,
        input logic            actual_taken,
        input logic [PC_W-1:0] actual_target
    );
        return (pred_taken != actual_taken) ||
               (actual_taken && (pred_target != actual_target));
    endfunction

    // Fall-through wraps naturally at 2^PC_W.
    function automatic logic [PC_W-1:0] correct_pc(
        input logic [PC_W-1:0] pc,
        input logic            actual_taken,
        input logic [PC_W-1:0] actual_target
    );
        return actual_taken ? actual_target : pc + PC_W'(1);
    endfunction

endpackage

// File: rtl/branch_compare.sv
// Per-slot combinational resolve: flags a mispredict and forms the correct next PC.
module branch_compare
    import branch_pkg::*;
(
    input  logic            valid,
    input  logic [PC_W-1:0] pc,
    input  logic            pred_taken,
    input  logic [PC_W-1:0] pred_target,
    input  logic            actual_taken,
    input  logic [PC_W-1:0] actual_target,
    output logic            mispredict,
    output logic [PC_W-1:0] correctPC
);

    assign mispredict = valid && is_mispredict(pred_taken, pred_target, actual_taken, actual_target);
    assign correctPC  = correct_pc(pc, actual_taken, actual_target);

endmodule

// File: rtl/branch_resolution_unit.sv
// Memory-stage branch resolution: predictor update strobes, fetch redirect,
// wrong-path flush window and saturating branch/mispredict statistics.
module branch_resolution_unit #(
    parameter int PC_W         = branch_pkg::PC_W,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             valid1,
    input  logic             valid2,
    input  logic [PC_W-1:0]  pcE1,
    input  logic [PC_W-1:0]  pcE2,
    input  logic             actualTaken1,
    input  logic             actualTaken2,
    input  logic [PC_W-1:0]  actualTarget1,
    input  logic [PC_W-1:0]  actualTarget2,
    input  logic             predTaken1,
    input  logic             predTaken2,
    input  logic [PC_W-1:0]  predTarget1,
    input  logic [PC_W-1:0]  predTarget2,
    output logic             branch1,
    output logic             branch2,
    output logic             branch_taken1,
    output logic             branch_taken2,
    output logic [PC_W-1:0]  pcM1,
    output logic [PC_W-1:0]  pcM2,
    output logic [PC_W-1:0]  targetM1,
    output logic [PC_W-1:0]  targetM2,
    output logic             redirect,
    output logic [PC_W-1:0]  redirectPC,
    output logic             flush,
    output logic [CNT_W-1:0] branchCount,
    output logic [CNT_W-1:0] mispredCount
);
    import branch_pkg::*;

    function automatic logic [CNT_W-1:0] sat_add(
        input logic [CNT_W-1:0] a,
        input logic [1:0]       inc
    );
        logic [CNT_W:0] sum;
        sum = {1'b0, a} + {{(CNT_W-1){1'b0}}, inc};
        return sum[CNT_W] ? '1 : sum[CNT_W-1:0];
    endfunction

    logic            mis1, mis2;
    logic [PC_W-1:0] cpc1, cpc2;

    branch_compare u_cmp1 (
        .valid         (valid1),
        .pc            (pcE1),
        .pred_taken    (predTaken1),
        .pred_target   (predTarget1),
        .actual_taken  (actualTaken1),
        .actual_target (actualTarget1),
        .mispredict    (mis1),
        .correctPC     (cpc1)
    );

    branch_compare u_cmp2 (
        .valid         (valid2),
        .pc            (pcE2),
        .pred_taken    (predTaken2),
        .pred_target   (predTarget2),
        .actual_taken  (actualTaken2),
        .actual_target (actualTarget2),
        .mispredict    (mis2),
        .correctPC     (cpc2)
    );

    bru_state_e       state_q, state_d;
    logic [3:0]       flush_cnt_q, flush_cnt_d;
    logic             branch1_q, branch1_d, branch2_q, branch2_d;
    logic             branch_taken1_q, branch_taken1_d, branch_taken2_q, branch_taken2_d;
    logic [PC_W-1:0]  pc_m1_q, pc_m1_d, pc_m2_q, pc_m2_d;
    logic [PC_W-1:0]  target_m1_q, target_m1_d, target_m2_q, target_m2_d;
    logic             redirect_q, redirect_d;
    logic [PC_W-1:0]  redirect_pc_q, redirect_pc_d;
    logic             flush_q, flush_d;
    logic [CNT_W-1:0] branch_count_q, branch_count_d;
    logic [CNT_W-1:0] mispred_count_q, mispred_count_d;

    logic accept, upd1, upd2, take_mis1, mis_any;
    logic [1:0] n_upd;

    always_comb begin
        accept    = !stall && (state_q == RUN);
        upd1      = accept && valid1;
        // A mispredicting slot 1 makes slot 2 wrong-path.
        upd2      = accept && valid2 && !mis1;
        take_mis1 = upd1 && mis1;
        mis_any   = take_mis1 || (upd2 && mis2);
        n_upd     = 2'(upd1) + 2'(upd2);

        state_d         = state_q;
        flush_cnt_d     = flush_cnt_q;
        branch1_d       = 1'b0;
        branch2_d       = 1'b0;
        branch_taken1_d = branch_taken1_q;
        branch_taken2_d = branch_taken2_q;
        pc_m1_d         = pc_m1_q;
        pc_m2_d         = pc_m2_q;
        target_m1_d     = target_m1_q;
        target_m2_d     = target_m2_q;
        redirect_d      = 1'b0;
        redirect_pc_d   = redirect_pc_q;
        flush_d         = flush_q;
        branch_count_d  = sat_add(branch_count_q, n_upd);
        mispred_count_d = sat_add(mispred_count_q, 2'(mis_any));

        if (upd1) begin
            branch1_d       = 1'b1;
            branch_taken1_d = actualTaken1;
            pc_m1_d         = pcE1;
            target_m1_d     = actualTarget1;
        end
        if (upd2) begin
            branch2_d       = 1'b1;
            branch_taken2_d = actualTaken2;
            pc_m2_d         = pcE2;
            target_m2_d     = actualTarget2;
        end

        if (mis_any) begin
            redirect_d    = 1'b1;
            redirect_pc_d = take_mis1 ? cpc1 : cpc2;
            state_d       = FLUSH;
            flush_d       = 1'b1;
            flush_cnt_d   = 4'(FLUSH_CYCLES - 1);
        end

        // The flush window only advances on non-stalled cycles.
        if (!stall && (state_q == FLUSH)) begin
            if (flush_cnt_q == 4'd0) begin
                state_d = RUN;
                flush_d = 1'b0;
            end else begin
                flush_cnt_d = flush_cnt_q - 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q         <= RUN;
            flush_cnt_q     <= '0;
            branch1_q       <= 1'b0;
            branch2_q       <= 1'b0;
            branch_taken1_q <= 1'b0;
            branch_taken2_q <= 1'b0;
            pc_m1_q         <= '0;
            pc_m2_q         <= '0;
            target_m1_q     <= '0;
            target_m2_q     <= '0;
            redirect_q      <= 1'b0;
            redirect_pc_q   <= '0;
            flush_q         <= 1'b0;
            branch_count_q  <= '0;
            mispred_count_q <= '0;
        end else begin
            state_q         <= state_d;
            flush_cnt_q     <= flush_cnt_d;
            branch1_q       <= branch1_d;
            branch2_q       <= branch2_d;
            branch_taken1_q <= branch_taken1_d;
            branch_taken2_q <= branch_taken2_d;
            pc_m1_q         <= pc_m1_d;
            pc_m2_q         <= pc_m2_d;
            target_m1_q     <= target_m1_d;
            target_m2_q     <= target_m2_d;
            redirect_q      <= redirect_d;
            redirect_pc_q   <= redirect_pc_d;
            flush_q         <= flush_d;
            branch_count_q  <= branch_count_d;
            mispred_count_q <= mispred_count_d;
        end
    end

    assign branch1       = branch1_q;
    assign branch2       = branch2_q;
    assign branch_taken1 = branch_taken1_q;
    assign branch_taken2 = branch_taken2_q;
    assign pcM1          = pc_m1_q;
    assign pcM2          = pc_m2_q;
    assign targetM1      = target_m1_q;
    assign targetM2      = target_m2_q;
    assign redirect      = redirect_q;
    assign redirectPC    = redirect_pc_q;
    assign flush         = flush_q;
    assign branchCount   = branch_count_q;
    assign mispredCount  = mispred_count_q;

endmodule

// File: tb/tb_branch_resolution_unit.sv
// Directed bench for branch_resolution_unit with a reference model feeding a scoreboard queue.
module tb_branch_resolution_unit;

    localparam int PC_W         = 11;
    localparam int FLUSH_CYCLES = 2;
    localparam int CNT_W        = 16;

    logic             clk = 1'b0;
    logic             reset, stall;
    logic             valid1, valid2;
    logic [PC_W-1:0]  pcE1, pcE2;
    logic             actualTaken1, actualTaken2;
    logic [PC_W-1:0]  actualTarget1, actualTarget2;
    logic             predTaken1, predTaken2;
    logic [PC_W-1:0]  predTarget1, predTarget2;
    logic             branch1, branch2, branch_taken1, branch_taken2;
    logic [PC_W-1:0]  pcM1, pcM2, targetM1, targetM2;
    logic             redirect;
    logic [PC_W-1:0]  redirectPC;
    logic             flush;
    logic [CNT_W-1:0] branchCount, mispredCount;

    branch_resolution_unit #(
        .PC_W(PC_W), .FLUSH_CYCLES(FLUSH_CYCLES), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset), .stall(stall),
        .valid1(valid1), .valid2(valid2),
        .pcE1(pcE1), .pcE2(pcE2),
        .actualTaken1(actualTaken1), .actualTaken2(actualTaken2),
        .actualTarget1(actualTarget1), .actualTarget2(actualTarget2),
        .predTaken1(predTaken1), .predTaken2(predTaken2),
        .predTarget1(predTarget1), .predTarget2(predTarget2),
        .branch1(branch1), .branch2(branch2),
        .branch_taken1(branch_taken1), .branch_taken2(branch_taken2),
        .pcM1(pcM1), .pcM2(pcM2), .targetM1(targetM1), .targetM2(targetM2),
        .redirect(redirect), .redirectPC(redirectPC), .flush(flush),
        .branchCount(branchCount), .mispredCount(mispredCount)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic b1, t1, d1;
        logic [PC_W-1:0] p1, g1;
        logic b2, t2, d2;
        logic [PC_W-1:0] p2, g2;
        logic red;
        logic [PC_W-1:0] rpc;
        logic fl;
        logic [CNT_W-1:0] bc, mc;
    } exp_t;

    exp_t  sb[$];
    int    n_checks = 0;
    int    n_fail   = 0;
    string cur      = "init";

    int              m_state = 0, m_cnt = 0, m_bc = 0, m_mc = 0;
    logic [PC_W-1:0] m_rpc = '0;
    logic            m_fl  = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s/%s: got %0h expected %0h", cur, tag, got, exp);
        end
    endtask

    function automatic bit ref_mis(bit pt, logic [PC_W-1:0] ptg, bit at, logic [PC_W-1:0] atg);
        return (pt != at) || (at && (ptg != atg));
    endfunction

    function automatic logic [PC_W-1:0] ref_cpc(bit at, logic [PC_W-1:0] atg, logic [PC_W-1:0] pc);
        return at ? atg : PC_W'((int'(pc) + 1) % (1 << PC_W));
    endfunction

    task automatic model_step(output exp_t e);
        bit ms1, ms2, u1, u2;
        e = '0;
        if (!reset) begin
            m_state = 0; m_cnt = 0; m_bc = 0; m_mc = 0; m_rpc = '0; m_fl = 1'b0;
            e.d1 = 1'b1; e.d2 = 1'b1;
        end else if (stall) begin
        end else if (m_state == 1) begin
            if (m_cnt == 0) begin m_state = 0; m_fl = 1'b0; end
            else m_cnt--;
        end else begin
            ms1 = valid1 && ref_mis(predTaken1, predTarget1, actualTaken1, actualTarget1);
            u1  = valid1;
            u2  = valid2 && !ms1;
            ms2 = u2 && ref_mis(predTaken2, predTarget2, actualTaken2, actualTarget2);
            e.b1 = u1; e.d1 = u1; e.t1 = actualTaken1; e.p1 = pcE1; e.g1 = actualTarget1;
            e.b2 = u2; e.d2 = u2; e.t2 = actualTaken2; e.p2 = pcE2; e.g2 = actualTarget2;
            if (ms1 || ms2) begin
                m_rpc   = ms1 ? ref_cpc(actualTaken1, actualTarget1, pcE1)
                              : ref_cpc(actualTaken2, actualTarget2, pcE2);
                e.red   = 1'b1;
                m_state = 1;
                m_cnt   = FLUSH_CYCLES - 1;
                m_fl    = 1'b1;
                m_mc    = (m_mc < 65535) ? m_mc + 1 : 65535;
            end
            m_bc = m_bc + int'(u1) + int'(u2);
            if (m_bc > 65535) m_bc = 65535;
        end
        e.rpc = m_rpc;
        e.fl  = m_fl;
        e.bc  = CNT_W'(m_bc);
        e.mc  = CNT_W'(m_mc);
    endtask

    task automatic slot1(bit v, int pc, bit pt, int ptg, bit at, int atg);
        valid1 = v; pcE1 = PC_W'(pc); predTaken1 = pt; predTarget1 = PC_W'(ptg);
        actualTaken1 = at; actualTarget1 = PC_W'(atg);
    endtask

    task automatic slot2(bit v, int pc, bit pt, int ptg, bit at, int atg);
        valid2 = v; pcE2 = PC_W'(pc); predTaken2 = pt; predTarget2 = PC_W'(ptg);
        actualTaken2 = at; actualTarget2 = PC_W'(atg);
    endtask

    task automatic idle();
        slot1(0, 0, 0, 0, 0, 0);
        slot2(0, 0, 0, 0, 0, 0);
    endtask

    task automatic step(input string name, input bit rst_n, input bit stl, input bit check);
        exp_t e;
        cur   = name;
        reset = rst_n;
        stall = stl;
        model_step(e);
        if (check) sb.push_back(e);
        @(posedge clk);
        #1;
        if (check && sb.size() > 0) begin
            e = sb.pop_front();
            chk("branch1",      32'(branch1),      32'(e.b1));
            chk("branch2",      32'(branch2),      32'(e.b2));
            chk("redirect",     32'(redirect),     32'(e.red));
            chk("redirectPC",   32'(redirectPC),   32'(e.rpc));
            chk("flush",        32'(flush),        32'(e.fl));
            chk("branchCount",  32'(branchCount),  32'(e.bc));
            chk("mispredCount", 32'(mispredCount), 32'(e.mc));
            if (e.d1) begin
                chk("branch_taken1", 32'(branch_taken1), 32'(e.t1));
                chk("pcM1",          32'(pcM1),          32'(e.p1));
                chk("targetM1",      32'(targetM1),      32'(e.g1));
            end
            if (e.d2) begin
                chk("branch_taken2", 32'(branch_taken2), 32'(e.t2));
                chk("pcM2",          32'(pcM2),          32'(e.p2));
                chk("targetM2",      32'(targetM2),      32'(e.g2));
            end
        end
    endtask

    initial begin
        reset = 1'b0;
        stall = 1'b0;
        idle();

        step("reset", 0, 0, 1);
        step("reset2", 0, 0, 1);

        slot1(1, 'h010, 1, 'h040, 1, 'h040);
        step("correct", 1, 0, 1);
        chk("tp_bc", 32'(branchCount), 32'd1);
        chk("tp_tgt", 32'(targetM1), 32'h040);

        slot1(1, 'h7FF, 1, 'h123, 0, 'h123);
        step("dirmis", 1, 0, 1);
        chk("tp_wrap_pc", 32'(redirectPC), 32'h000);
        chk("tp_redirect", 32'(redirect), 32'd1);

        slot1(1, 'h020, 0, 0, 0, 0);
        slot2(1, 'h021, 0, 0, 0, 0);
        step("flushA", 1, 0, 1);
        chk("tp_flushA", 32'(flush), 32'd1);
        step("flushB", 1, 0, 1);
        chk("tp_flushB_b1", 32'(branch1), 32'd0);
        idle();
        step("postflush", 1, 0, 1);
        chk("tp_flush_off", 32'(flush), 32'd0);

        slot1(1, 'h050, 1, 'h020, 1, 'h030);
        slot2(1, 'h051, 1, 'h070, 1, 'h070);
        step("dual_s1mis", 1, 0, 1);
        chk("tp_rpc030", 32'(redirectPC), 32'h030);
        idle();
        step("fl1", 1, 0, 1);
        step("fl2", 1, 0, 1);

        slot1(1, 'h060, 0, 0, 0, 0);
        slot2(1, 'h061, 0, 0, 1, 'h100);
        step("s2mis", 1, 0, 1);
        chk("tp_rpc100", 32'(redirectPC), 32'h100);
        chk("tp_b2", 32'(branch2), 32'd1);
        idle();
        step("fl3", 1, 0, 1);
        step("fl4", 1, 0, 1);

        slot1(1, 'h0A0, 0, 0, 1, 'h0B0);
        slot2(1, 'h0A1, 0, 0, 1, 'h0C0);
        step("bothmis", 1, 0, 1);
        chk("tp_rpc0b0", 32'(redirectPC), 32'h0B0);
        idle();
        step("stall_fl1", 1, 1, 1);
        step("stall_fl2", 1, 1, 1);
        step("fl5", 1, 0, 1);
        step("fl6", 1, 0, 1);
        step("run_idle", 1, 0, 1);

        slot1(1, 'h200, 0, 0, 0, 0);
        step("stall_run", 1, 1, 1);
        chk("tp_stall_b1", 32'(branch1), 32'd0);
        step("unstall", 1, 0, 1);

        slot1(1, 'h300, 0, 0, 1, 'h310);
        step("mis_pre_rst", 1, 0, 1);
        step("rst_midflush", 0, 0, 1);
        slot1(1, 'h400, 0, 0, 0, 0);
        step("after_rst", 1, 0, 1);
        chk("tp_after_rst_bc", 32'(branchCount), 32'd1);

        slot1(1, 'h010, 1, 'h040, 1, 'h040);
        slot2(1, 'h011, 0, 0, 0, 0);
        for (int i = 0; i < 32766; i++) step("sat_fill", 1, 0, 0);
        slot2(0, 0, 0, 0, 0, 0);
        step("sat_fffe", 1, 0, 1);
        chk("tp_fffe", 32'(branchCount), 32'hFFFE);
        slot2(1, 'h011, 0, 0, 0, 0);
        step("sat_cross", 1, 0, 1);
        chk("tp_ffff", 32'(branchCount), 32'hFFFF);
        step("sat_hold", 1, 0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
